// File: rtl/biriscv_dbg_csr_master_pkg.sv
// Shared definitions for the debug CSR master: error codes, FSM states, CSR address width.
package biriscv_dbg_csr_master_pkg;

  localparam int DBG_CSR_AW = 12;

  typedef enum logic [1:0] {
    DBG_ERR_OK     = 2'd0,
    DBG_ERR_BUSY   = 2'd1,
    DBG_ERR_HALT   = 2'd2,
    DBG_ERR_VERIFY = 2'd3
  } dbg_err_e;

  typedef enum logic [2:0] {
    DBG_ST_IDLE = 3'd0,
    DBG_ST_RST  = 3'd1,
    DBG_ST_WR   = 3'd2,
    DBG_ST_RD   = 3'd3,
    DBG_ST_RSP  = 3'd4
  } dbg_state_e;

endpackage

// File: rtl/biriscv_dbg_csr_master.sv
// Debug-side sequencer for the core's JTAG CSR port: one abstract command at a time, one response each.
// Define DBG_CSR_VERIFY_EN to read back every write and flag a mismatch.
module biriscv_dbg_csr_master
  import biriscv_dbg_csr_master_pkg::*;
#(
  parameter int READ_LAT   = 1,
  parameter int WR_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic                  cmd_reset_i,
  input  logic [DBG_CSR_AW-1:0] cmd_addr_i,
  input  logic [31:0]           cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic [1:0]            rsp_err_o,
  input  logic                  halted_i,
  input  logic                  csr_wb_busy_i,
  output logic                  jtag_reset_req_o,
  output logic                  jtag_csr_write_o,
  output logic [DBG_CSR_AW-1:0] jtag_csr_waddr_o,
  output logic [31:0]           jtag_csr_data_wr_o,
  output logic [DBG_CSR_AW-1:0] jtag_csr_raddr_o,
  input  logic [31:0]           jtag_csr_data_rd_i
);

  localparam logic [7:0] RD_LAST = 8'(READ_LAT - 1);
  localparam logic [7:0] WR_LAST = 8'(WR_TIMEOUT - 1);

  dbg_state_e            state_q, state_d;
  dbg_err_e              err_q, err_d;
  logic [DBG_CSR_AW-1:0] addr_q, addr_d;
  logic [DBG_CSR_AW-1:0] raddr_q, raddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  ready_q, ready_d;
`ifdef DBG_CSR_VERIFY_EN
  logic                  is_wr_q, is_wr_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DBG_ST_IDLE;
      err_q   <= DBG_ERR_OK;
      addr_q  <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
`ifdef DBG_CSR_VERIFY_EN
      is_wr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      raddr_q <= raddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
`ifdef DBG_CSR_VERIFY_EN
      is_wr_q <= is_wr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    addr_d  = addr_q;
    raddr_d = raddr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
`ifdef DBG_CSR_VERIFY_EN
    is_wr_d = is_wr_q;
`endif
    unique case (state_q)
      DBG_ST_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          rdata_d = '0;
          err_d   = DBG_ERR_OK;
          cnt_d   = '0;
`ifdef DBG_CSR_VERIFY_EN
          is_wr_d = cmd_write_i;
`endif
          // Reset needs no halt; a CSR command on a running core leaves the port untouched.
          if (cmd_reset_i) begin
            state_d = DBG_ST_RST;
          end else if (!halted_i) begin
            err_d   = DBG_ERR_HALT;
            state_d = DBG_ST_RSP;
          end else if (cmd_write_i) begin
            state_d = DBG_ST_WR;
          end else begin
            raddr_d = cmd_addr_i;
            state_d = DBG_ST_RD;
          end
        end
      end
      DBG_ST_RST: state_d = DBG_ST_RSP;
      DBG_ST_WR: begin
        if (!csr_wb_busy_i) begin
`ifdef DBG_CSR_VERIFY_EN
          raddr_d = addr_q;
          cnt_d   = '0;
          state_d = DBG_ST_RD;
`else
          state_d = DBG_ST_RSP;
`endif
        end else if (cnt_q == WR_LAST) begin
          err_d   = DBG_ERR_BUSY;
          state_d = DBG_ST_RSP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DBG_ST_RD: begin
        if (cnt_q == RD_LAST) begin
          rdata_d = jtag_csr_data_rd_i;
          state_d = DBG_ST_RSP;
`ifdef DBG_CSR_VERIFY_EN
          // WARL fields can legitimately differ; the debug module decides whether to mask this.
          if (is_wr_q && (jtag_csr_data_rd_i != wdata_q)) err_d = DBG_ERR_VERIFY;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DBG_ST_RSP: begin
        if (rsp_ready_i) state_d = DBG_ST_IDLE;
      end
      default: state_d = DBG_ST_IDLE;
    endcase
    ready_d = (state_d == DBG_ST_IDLE);
  end

  assign cmd_ready_o        = ready_q;
  assign rsp_valid_o        = (state_q == DBG_ST_RSP);
  assign rsp_rdata_o        = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o          = rsp_valid_o ? err_q : DBG_ERR_OK;
  assign jtag_reset_req_o   = (state_q == DBG_ST_RST);
  assign jtag_csr_write_o   = (state_q == DBG_ST_WR);
  assign jtag_csr_waddr_o   = jtag_csr_write_o ? addr_q : '0;
  assign jtag_csr_data_wr_o = jtag_csr_write_o ? wdata_q : '0;
  assign jtag_csr_raddr_o   = raddr_q;

endmodule

// File: tb/tb_biriscv_dbg_csr_master.sv
// Directed bench for biriscv_dbg_csr_master; expectations follow DBG_CSR_VERIFY_EN when defined.
module tb_biriscv_dbg_csr_master;

  localparam int READ_LAT   = 1;
  localparam int WR_TIMEOUT = 4;
`ifdef DBG_CSR_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_reset = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_ready = 1'b0, halted = 1'b0, wb_busy = 1'b0;
  logic [31:0] rd_val = '0;
  logic        cmd_ready_o, rsp_valid_o, jtag_reset_req_o, jtag_csr_write_o;
  logic [31:0] rsp_rdata_o, jtag_csr_data_wr_o, jtag_csr_data_rd_i;
  logic [1:0]  rsp_err_o;
  logic [11:0] jtag_csr_waddr_o, jtag_csr_raddr_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign jtag_csr_data_rd_i = (jtag_csr_raddr_o == 12'h341) ? 32'h8000_0010 : rd_val;

  biriscv_dbg_csr_master #(.READ_LAT(READ_LAT), .WR_TIMEOUT(WR_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
    .cmd_reset_i(cmd_reset), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .halted_i(halted), .csr_wb_busy_i(wb_busy),
    .jtag_reset_req_o(jtag_reset_req_o), .jtag_csr_write_o(jtag_csr_write_o),
    .jtag_csr_waddr_o(jtag_csr_waddr_o), .jtag_csr_data_wr_o(jtag_csr_data_wr_o),
    .jtag_csr_raddr_o(jtag_csr_raddr_o), .jtag_csr_data_rd_i(jtag_csr_data_rd_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a command, wait (bounded) for acceptance, return at accept edge + 1.
  task automatic send_cmd(input logic w, input logic r, input logic [11:0] a, input logic [31:0] d);
    int t = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_reset = r; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready_o && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check_eq("cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Cycles after the accept edge until rsp_valid, counting strobes seen on the way.
  task automatic run_rsp(input int busy_n, output int cyc, output int wr_cnt,
                         output int wr_busy, output int rr_cnt);
    cyc = 0; wr_cnt = 0; wr_busy = 0; rr_cnt = 0;
    while (!rsp_valid_o && cyc < 50) begin
      wb_busy = (cyc < busy_n);
      if (jtag_csr_write_o) begin
        wr_cnt++;
        if (wb_busy) wr_busy++;
      end
      if (jtag_reset_req_o) rr_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    wb_busy = 1'b0;
    check_eq("rsp_valid_seen", {31'd0, rsp_valid_o}, 32'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("rsp_dropped", {31'd0, rsp_valid_o}, 32'd0);
  endtask

  initial begin
    int cyc, wr_cnt, wr_busy, rr_cnt;
    logic [11:0] last_raddr;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check_eq("rst_write", {31'd0, jtag_csr_write_o}, 32'd0);
    check_eq("rst_reset_req", {31'd0, jtag_reset_req_o}, 32'd0);
    check_eq("rst_raddr", {20'd0, jtag_csr_raddr_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    halted = 1'b1;

    // 1: read 0x341
    send_cmd(1'b0, 1'b0, 12'h341, 32'h0);
    check_eq("rd_raddr", {20'd0, jtag_csr_raddr_o}, 32'h341);
    run_rsp(0, cyc, wr_cnt, wr_busy, rr_cnt);
    check_eq("rd_latency", cyc, READ_LAT);
    check_eq("rd_rdata", rsp_rdata_o, 32'h8000_0010);
    check_eq("rd_err", {30'd0, rsp_err_o}, 32'd0);
    check_eq("rd_no_write", wr_cnt, 0);
    $display("txn read  addr=0x341 cyc=%0d rdata=0x%08h err=%0d", cyc, rsp_rdata_o, rsp_err_o);
    consume();
    last_raddr = 12'h341;

    // 2: write 0x305 with three busy cycles
    rd_val = 32'h0000_0100;
    send_cmd(1'b1, 1'b0, 12'h305, 32'h0000_0100);
    check_eq("wr_strobe", {31'd0, jtag_csr_write_o}, 32'd1);
    check_eq("wr_waddr", {20'd0, jtag_csr_waddr_o}, 32'h305);
    check_eq("wr_wdata", jtag_csr_data_wr_o, 32'h100);
    run_rsp(3, cyc, wr_cnt, wr_busy, rr_cnt);
    check_eq("wr_strobe_cycles", wr_cnt, 4);
    check_eq("wr_busy_cycles", wr_busy, 3);
    check_eq("wr_latency", cyc, 4 + VER * READ_LAT);
    check_eq("wr_err", {30'd0, rsp_err_o}, 32'd0);
    check_eq("wr_rdata", rsp_rdata_o, (VER == 1) ? 32'h100 : 32'h0);
    check_eq("wr_strobe_off", {31'd0, jtag_csr_write_o}, 32'd0);
    $display("txn write addr=0x305 cyc=%0d rdata=0x%08h err=%0d", cyc, rsp_rdata_o, rsp_err_o);
    consume();
    if (VER == 1) last_raddr = 12'h305;

    // 3: busy stuck -> timeout
    send_cmd(1'b1, 1'b0, 12'h340, 32'hdead_beef);
    run_rsp(1000, cyc, wr_cnt, wr_busy, rr_cnt);
    check_eq("to_latency", cyc, WR_TIMEOUT);
    check_eq("to_strobe_cycles", wr_cnt, WR_TIMEOUT);
    check_eq("to_err", {30'd0, rsp_err_o}, 32'd1);
    check_eq("to_strobe_off", {31'd0, jtag_csr_write_o}, 32'd0);
    check_eq("to_raddr_kept", {20'd0, jtag_csr_raddr_o}, {20'd0, last_raddr});
    $display("txn write addr=0x340 busy-stuck cyc=%0d err=%0d", cyc, rsp_err_o);
    consume();

    // 4: not halted read, then reset request
    halted = 1'b0;
    send_cmd(1'b0, 1'b0, 12'h300, 32'h0);
    run_rsp(0, cyc, wr_cnt, wr_busy, rr_cnt);
    check_eq("nh_latency", cyc, 0);
    check_eq("nh_err", {30'd0, rsp_err_o}, 32'd2);
    check_eq("nh_raddr_kept", {20'd0, jtag_csr_raddr_o}, {20'd0, last_raddr});
    check_eq("nh_rdata", rsp_rdata_o, 32'h0);
    $display("txn read  addr=0x300 not-halted err=%0d", rsp_err_o);
    consume();
    send_cmd(1'b0, 1'b1, 12'h7ff, 32'h1234_5678);
    run_rsp(0, cyc, wr_cnt, wr_busy, rr_cnt);
    check_eq("rr_latency", cyc, 1);
    check_eq("rr_pulses", rr_cnt, 1);
    check_eq("rr_pulse_off", {31'd0, jtag_reset_req_o}, 32'd0);
    check_eq("rr_err", {30'd0, rsp_err_o}, 32'd0);
    check_eq("rr_rdata", rsp_rdata_o, 32'h0);
    check_eq("rr_no_write", wr_cnt, 0);
    $display("txn reset cyc=%0d err=%0d", cyc, rsp_err_o);
    consume();
    halted = 1'b1;

    // 5: write all-ones, CSR reads back zero
    rd_val = 32'h0;
    send_cmd(1'b1, 1'b0, 12'h340, 32'hffff_ffff);
    run_rsp(0, cyc, wr_cnt, wr_busy, rr_cnt);
    check_eq("vf_latency", cyc, 1 + VER * READ_LAT);
    check_eq("vf_err", {30'd0, rsp_err_o}, (VER == 1) ? 32'd3 : 32'd0);
    check_eq("vf_rdata", rsp_rdata_o, 32'h0);
    $display("txn write addr=0x340 data=0xffffffff err=%0d", rsp_err_o);
    consume();

    // 6: response backpressure with a pending command, then reset during RD
    rd_val = 32'h1234_5678;
    send_cmd(1'b0, 1'b0, 12'h7c0, 32'h0);
    run_rsp(0, cyc, wr_cnt, wr_busy, rr_cnt);
    check_eq("bp_rdata", rsp_rdata_o, 32'h1234_5678);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_reset = 1'b0; cmd_addr = 12'h341;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp_valid_held", {31'd0, rsp_valid_o}, 32'd1);
      check_eq("bp_rdata_held", rsp_rdata_o, 32'h1234_5678);
      check_eq("bp_not_ready", {31'd0, cmd_ready_o}, 32'd0);
    end
    $display("txn read  addr=0x7c0 held 5 cycles rdata=0x%08h", rsp_rdata_o);
    consume();
    check_eq("bp_idle_ready", {31'd0, cmd_ready_o}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_eq("ab_in_rd_raddr", {20'd0, jtag_csr_raddr_o}, 32'h341);
    check_eq("ab_in_rd_ready", {31'd0, cmd_ready_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("ab_rst_ready", {31'd0, cmd_ready_o}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("ab_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    end
    check_eq("ab_ready_again", {31'd0, cmd_ready_o}, 32'd1);
    $display("txn read  addr=0x341 aborted by rst_n");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
